// File: rtl/gshare_idx_ctrl.sv
// gshare index/GHR controller: sole master of the PHT port, serving lookups and 2-bit counter updates.
// Ports: pred_* lookup req/resp, upd_* resolve update, pht_* table port, ghr_out debug history.
module gshare_idx_ctrl #(
  parameter int PC_W  = 32,
  parameter int IDX_W = 14,
  parameter int GHR_W = 14
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pred_valid,
  input  logic [PC_W-1:0]  pred_pc,
  output logic             pred_ready,
  output logic             pred_out_valid,
  output logic             pred_taken,
  output logic [IDX_W-1:0] pred_idx,
  output logic [GHR_W-1:0] pred_ghr,
  input  logic             upd_valid,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken,
  input  logic             upd_mispredict,
  input  logic [GHR_W-1:0] upd_ghr,
  output logic             upd_ready,
  output logic [IDX_W-1:0] pht_addr,
  output logic             pht_wr_en,
  output logic [1:0]       pht_wr_data,
  input  logic [1:0]       pht_rd_data,
  output logic [GHR_W-1:0] ghr_out
);

  typedef enum logic [1:0] {
    IDLE,
    UPD_RD,
    UPD_WR
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [GHR_W-1:0] ghr;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] addr_q;
  logic [IDX_W-1:0] u_idx;
  logic             u_taken;
  logic [1:0]       ctr;
  logic [1:0]       ctr_nx;
  logic             pred_fire;
  logic             upd_fire;
  logic             unused;

  assign unused = ^{pred_pc[PC_W-1:IDX_W+2],
                    pred_pc[1:0],
                    upd_ghr[GHR_W-1]};

  assign idx        = pred_pc[IDX_W+1:2] ^ IDX_W'(ghr);
  assign upd_ready  = (state == IDLE) & reset;
  assign pred_ready = (state == IDLE) & ~upd_valid & reset;
  assign pred_fire  = pred_valid & pred_ready;
  assign upd_fire   = upd_valid & upd_ready;
  assign ghr_out    = ghr;

  always_comb begin
    ctr_nx = ctr;
    unique case (1'b1)
      (u_taken & (ctr != 2'b11)):  ctr_nx = ctr + 2'd1;
      (~u_taken & (ctr != 2'b00)): ctr_nx = ctr - 2'd1;
      default:                     ctr_nx = ctr;
    endcase
  end

  // Address holds its last value whenever nobody uses the port.
  always_comb begin
    state_nx    = state;
    pht_addr    = addr_q;
    pht_wr_en   = 1'b0;
    pht_wr_data = 2'b00;
    unique case (state)
      IDLE: begin
        if (upd_fire) begin
          state_nx = UPD_RD;
        end else if (pred_fire) begin
          pht_addr = idx;
        end
      end
      UPD_RD: begin
        pht_addr = u_idx;
        state_nx = UPD_WR;
      end
      UPD_WR: begin
        pht_addr    = u_idx;
        pht_wr_en   = 1'b1;
        pht_wr_data = ctr_nx;
        state_nx    = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      ghr            <= '0;
      addr_q         <= '0;
      pred_out_valid <= 1'b0;
      pred_taken     <= 1'b0;
      pred_idx       <= '0;
      pred_ghr       <= '0;
      u_idx          <= '0;
      u_taken        <= 1'b0;
      ctr            <= 2'b00;
    end else begin
      state          <= state_nx;
      addr_q         <= pht_addr;
      pred_out_valid <= pred_fire;
      if (pred_fire) begin
        pred_taken <= pht_rd_data[1];
        pred_idx   <= idx;
        pred_ghr   <= ghr;
        ghr        <= {ghr[GHR_W-2:0], pht_rd_data[1]};
      end
      // Update and prediction never fire together, so one GHR writer per edge.
      if (upd_fire) begin
        u_idx   <= upd_idx;
        u_taken <= upd_taken;
        if (upd_mispredict) begin
          ghr <= {upd_ghr[GHR_W-2:0], upd_taken};
        end
      end
      if (state == UPD_RD) begin
        ctr <= pht_rd_data;
      end
    end
  end

endmodule

// File: tb/tb_gshare_idx_ctrl.sv
// Testbench for gshare_idx_ctrl: PHT array, transaction-level model, per-cycle compare.
// Directed vectors with literal expectations pinning the model.
module tb_gshare_idx_ctrl;
  localparam int PC_W  = 32;
  localparam int IDX_W = 14;
  localparam int GHR_W = 14;
  localparam int MASK  = (1 << 14) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             pred_valid = 1'b0;
  logic [PC_W-1:0]  pred_pc = '0;
  logic             pred_ready;
  logic             pred_out_valid;
  logic             pred_taken;
  logic [IDX_W-1:0] pred_idx;
  logic [GHR_W-1:0] pred_ghr;
  logic             upd_valid = 1'b0;
  logic [IDX_W-1:0] upd_idx = '0;
  logic             upd_taken = 1'b0;
  logic             upd_mispredict = 1'b0;
  logic [GHR_W-1:0] upd_ghr = '0;
  logic             upd_ready;
  logic [IDX_W-1:0] pht_addr;
  logic             pht_wr_en;
  logic [1:0]       pht_wr_data;
  logic [1:0]       pht_rd_data;
  logic [GHR_W-1:0] ghr_out;

  gshare_idx_ctrl #(
    .PC_W(PC_W), .IDX_W(IDX_W), .GHR_W(GHR_W)
  ) dut (
    .clk(clk), .reset(rst_n),
    .pred_valid(pred_valid), .pred_pc(pred_pc),
    .pred_ready(pred_ready), .pred_out_valid(pred_out_valid),
    .pred_taken(pred_taken), .pred_idx(pred_idx),
    .pred_ghr(pred_ghr), .upd_valid(upd_valid),
    .upd_idx(upd_idx), .upd_taken(upd_taken),
    .upd_mispredict(upd_mispredict), .upd_ghr(upd_ghr),
    .upd_ready(upd_ready), .pht_addr(pht_addr),
    .pht_wr_en(pht_wr_en), .pht_wr_data(pht_wr_data),
    .pht_rd_data(pht_rd_data), .ghr_out(ghr_out)
  );

  always #5 clk = ~clk;

  logic [1:0] pht [0:MASK];
  assign pht_rd_data = pht[pht_addr];
  always @(posedge clk) if (pht_wr_en) pht[pht_addr] <= pht_wr_data;

  int n_run = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int sat(input int c, input int t);
    if (t != 0) return (c == 3) ? 3 : c + 1;
    return (c == 0) ? 0 : c - 1;
  endfunction

  // Model: GHR as an integer, update occupancy as a countdown
  // (2 = read cycle, 1 = write cycle), PHT as a plain array.
  int m_pht [0:MASK];
  int m_ghr = 0;
  int m_busy = 0;
  int m_uidx = 0;
  int m_utaken = 0;
  int m_i;
  bit e_pv = 0;
  int e_pt = 0;
  int e_pi = 0;
  int e_pg = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_ghr = 0;
      m_busy = 0;
      e_pv = 0;
    end else begin
      e_pv = 0;
      if (m_busy == 0 && upd_valid) begin
        m_uidx = int'(upd_idx);
        m_utaken = int'(upd_taken);
        if (upd_mispredict)
          m_ghr = ((int'(upd_ghr) << 1) | m_utaken) & MASK;
        m_busy = 2;
      end else if (m_busy == 0 && pred_valid) begin
        m_i = (int'(pred_pc >> 2) & MASK) ^ m_ghr;
        e_pv = 1;
        e_pt = m_pht[m_i] / 2;
        e_pi = m_i;
        e_pg = m_ghr;
        m_ghr = ((m_ghr << 1) | e_pt) & MASK;
      end else if (m_busy == 2) begin
        m_busy = 1;
      end else if (m_busy == 1) begin
        m_pht[m_uidx] = sat(m_pht[m_uidx], m_utaken);
        m_busy = 0;
      end
    end
  end

  bit ep_rdy;
  bit eu_rdy;
  always @(negedge clk) begin
    eu_rdy = rst_n && m_busy == 0;
    ep_rdy = eu_rdy && !upd_valid;
    chk("pred_ready", pred_ready, ep_rdy);
    chk("upd_ready", upd_ready, eu_rdy);
    chk("ghr_out", ghr_out, m_ghr);
    chk("wr_en", pht_wr_en, m_busy == 1);
    chk("pred_out_valid", pred_out_valid, e_pv);
    if (e_pv) begin
      chk("pred_taken", pred_taken, e_pt);
      chk("pred_idx", pred_idx, e_pi);
      chk("pred_ghr", pred_ghr, e_pg);
    end
    if (m_busy == 1)
      chk("wr_data", pht_wr_data, sat(m_pht[m_uidx], m_utaken));
    else
      chk("wr_data_idle", pht_wr_data, 0);
    if (m_busy > 0)
      chk("upd_addr", pht_addr, m_uidx);
    else if (ep_rdy && pred_valid)
      chk("pred_addr", pht_addr,
          (int'(pred_pc >> 2) & MASK) ^ m_ghr);
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic set_pht(input int i, input int v);
    pht[i] = 2'(v);
    m_pht[i] = v;
  endtask

  task automatic do_upd(input int idx, input int t, input int m,
                        input int g, input int exp_wd,
                        input int exp_ghr);
    bit seen;
    upd_valid = 1'b1;
    upd_idx = IDX_W'(idx);
    upd_taken = t[0];
    upd_mispredict = m[0];
    upd_ghr = GHR_W'(g);
    #1;
    chk("upd accept", upd_ready, 1);
    step();
    upd_valid = 1'b0;
    upd_mispredict = 1'b0;
    if (exp_ghr >= 0) chk("repair ghr", ghr_out, exp_ghr);
    seen = 0;
    for (int k = 0; k < 4 && !seen; k++) begin
      if (pht_wr_en) begin
        seen = 1;
        chk("upd wr_data lit", pht_wr_data, exp_wd);
        chk("upd wr_addr lit", pht_addr, idx);
      end else begin
        step();
      end
    end
    if (!seen) begin
      n_run++;
      n_fail++;
      $display("FAIL upd timeout: got no write expected write idx %0d", idx);
    end
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i <= MASK; i++) set_pht(i, 0);
    set_pht(4, 2);
    set_pht(5, 3);
    set_pht(7, 2);
    set_pht(15, 1);
    set_pht(20, 1);
    step();
    step();
    pred_valid = 1'b1;
    #1;
    chk("rst pred_ready", pred_ready, 0);
    chk("rst upd_ready", upd_ready, 0);
    chk("rst pht_addr", pht_addr, 0);
    chk("rst pred_out_valid", pred_out_valid, 0);
    pred_valid = 1'b0;
    rst_n = 1'b1;
    step();

    pred_valid = 1'b1;
    pred_pc = 32'h10;
    #1;
    chk("p1 addr", pht_addr, 4);
    step();
    chk("p1 valid", pred_out_valid, 1);
    chk("p1 taken", pred_taken, 1);
    chk("p1 idx", pred_idx, 4);
    chk("p1 ghr", pred_ghr, 0);
    chk("p1 ghr_out", ghr_out, 1);
    chk("p2 addr", pht_addr, 5);
    step();
    chk("p2 ghr_out", ghr_out, 3);
    chk("p3 addr", pht_addr, 7);
    step();
    pred_valid = 1'b0;
    chk("p3 ghr_out", ghr_out, 7);
    chk("p3 idx", pred_idx, 7);
    step();

    do_upd(5, 1, 0, 0, 3, -1);
    set_pht(5, 0);
    do_upd(5, 0, 0, 0, 0, -1);
    set_pht(5, 1);
    do_upd(5, 1, 0, 0, 2, -1);
    do_upd(5, 0, 0, 0, 1, -1);

    pred_valid = 1'b1;
    pred_pc = 32'h20;
    upd_valid = 1'b1;
    upd_idx = 14'd9;
    upd_taken = 1'b1;
    #1;
    chk("coll upd_ready", upd_ready, 1);
    chk("coll pred_ready c1", pred_ready, 0);
    step();
    upd_valid = 1'b0;
    #1;
    chk("coll pred_ready c2", pred_ready, 0);
    step();
    chk("coll pred_ready c3", pred_ready, 0);
    step();
    chk("coll pred_ready c4", pred_ready, 1);
    chk("coll addr", pht_addr, 15);
    step();
    pred_valid = 1'b0;
    chk("coll valid", pred_out_valid, 1);
    chk("coll idx", pred_idx, 15);
    chk("coll taken", pred_taken, 0);
    chk("coll ghr_out", ghr_out, 14);
    step();

    do_upd(9, 1, 1, 7, 2, 15);
    do_upd(9, 0, 1, 3, 1, 6);

    upd_valid = 1'b1;
    upd_idx = 14'd20;
    upd_taken = 1'b1;
    step();
    upd_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("abort ghr_out", ghr_out, 0);
    chk("abort upd_ready", upd_ready, 0);
    chk("abort wr_en", pht_wr_en, 0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("abort no write", pht_wr_en, 0);
    end
    chk("abort pht kept", pht[20], 1);
    rst_n = 1'b1;
    #1;
    chk("release upd_ready", upd_ready, 1);
    step();
    do_upd(20, 1, 0, 0, 2, -1);
    step();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/gshare_idx_ctrl.md
Name: gshare_idx_ctrl

Overview:
- Sits directly upstream of the pattern history table (pat_tab) and is the only master of its single port (addr, wr_en, wr_data, rd_data).
- Serves two request streams: fetch-side prediction lookups, and resolve-side 2-bit counter updates (read-modify-write).
- Forms the gshare index pc[IDX_W+1:2] XOR ghr and maintains the speculative global history register (GHR) with misprediction repair.

Parameters:
- PC_W, 32, fetch/branch PC width
- IDX_W, 14, PHT index width; equals pat_tab addr width
- GHR_W, 14, global history length; must be <= IDX_W; zero-extended to IDX_W before the XOR

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- pred_valid  in  1  prediction request
- pred_pc  in  PC_W  PC of fetched branch
- pred_ready  out  1  prediction request accepted this cycle
- pred_out_valid  out  1  one-cycle pulse, prediction result valid
- pred_taken  out  1  predicted direction
- pred_idx  out  IDX_W  PHT index used; travels with the branch to resolve
- pred_ghr  out  GHR_W  GHR before this prediction's shift; repair checkpoint
- upd_valid  in  1  resolve/update request
- upd_idx  in  IDX_W  index returned from pred_idx
- upd_taken  in  1  actual outcome
- upd_mispredict  in  1  prediction was wrong; repair GHR
- upd_ghr  in  GHR_W  checkpoint returned from pred_ghr
- upd_ready  out  1  update request accepted this cycle
- pht_addr  out  IDX_W  to pat_tab addr
- pht_wr_en  out  1  to pat_tab wr_en
- pht_wr_data  out  2  to pat_tab wr_data
- pht_rd_data  in  2  from pat_tab rd_data; combinational read of pht_addr
- ghr_out  out  GHR_W  current GHR, for debug/perf

Behaviour:
- PHT contract: rd_data reflects addr in the same cycle; write occurs on the rising edge when wr_en=1.
- Reset (reset=0, asynchronous):
  - state=IDLE; ghr=0.
  - All outputs 0: pred_out_valid, pred_taken, pred_idx, pred_ghr, pht_addr, pht_wr_en, pht_wr_data.
  - pred_ready=0 and upd_ready=0 while reset is asserted.
- FSM states: IDLE, UPD_RD, UPD_WR.
- Arbitration: update beats prediction.
  - upd_ready = (state==IDLE) & reset_n.
  - pred_ready = (state==IDLE) & ~upd_valid & reset_n.
- Prediction, IDLE only, pred_valid & pred_ready:
  - Combinationally: pht_addr = idx = pred_pc[IDX_W+1:2] ^ {0, ghr}.
  - At the clock edge: pred_taken <= pht_rd_data[1]; pred_idx <= idx; pred_ghr <= ghr; ghr <= {ghr[GHR_W-2:0], pht_rd_data[1]}.
  - pred_out_valid=1 for exactly the following cycle. Latency 1; throughput 1 per cycle with no updates pending.
- Update, IDLE, upd_valid:
  - Latch upd_idx, upd_taken, upd_mispredict, upd_ghr; go to UPD_RD.
  - UPD_RD: pht_addr=latched idx; latch ctr=pht_rd_data; go to UPD_WR.
  - UPD_WR: pht_addr=latched idx; pht_wr_en=1; pht_wr_data=next(ctr); go to IDLE. The write is always issued, even if the value is unchanged.
  - Occupancy 3 cycles (accept, read, write); upd_ready low in UPD_RD and UPD_WR.
- Counter next(ctr), saturating, 00 SN / 01 WN / 10 WT / 11 ST:
  - taken: 11 stays 11, else ctr+1.
  - not taken: 00 stays 00, else ctr-1.
- GHR repair:
  - Applied at the accept edge when upd_mispredict=1: ghr <= {upd_ghr[GHR_W-2:0], upd_taken}.
  - No prediction can be accepted that same cycle, so there is no GHR write conflict.
  - No repair when upd_mispredict=0.
- Idle port:
  - pht_addr holds its last value; pht_wr_en=0 in every state except UPD_WR.
  - pht_wr_data=0 when not writing.
- Boundary cases:
  - Index uses PC bits only above [1:0]; the XOR wraps naturally within IDX_W bits.
  - A pred_valid held while upd_valid is high stalls (pred_ready=0) without being lost.
  - Back-to-back updates to the same idx serialize; the second reads the first's written value.
  - reset asserted in UPD_RD or UPD_WR aborts the update with no write; the latched update is discarded.

Test Plan:
- Reset, then pred_valid with pred_pc=0x0000_0010, ghr=0, PHT[4]=2'b10 -> pht_addr=4; next cycle pred_out_valid=1, pred_taken=1, pred_idx=4, pred_ghr=0; ghr_out=1.
- Three predictions pc=0x10, all returning taken -> ghr 0→1→3→7; third lookup pht_addr=4^3=7.
- Update idx=5, PHT[5]=11, taken=1 -> UPD_WR writes 11. Repeat with 00 and taken=0 -> writes 00. 01 taken -> 10; 10 not taken -> 01.
- pred_valid and upd_valid asserted in the same cycle -> upd_ready=1, pred_ready=0 for 3 cycles; prediction accepted in the 4th cycle with correct result.
- Mispredict: ghr=0x0F, upd_mispredict=1, upd_ghr=0x03, upd_taken=0 -> ghr_out=0x06 the cycle after accept.
- reset pulsed low during UPD_RD -> pht_wr_en never asserts; ghr_out=0, state IDLE; an update issued after release completes normally.
